// File: rtl/pwm_capture_if.sv
// ============================================================================
// Module   : pwm_capture_if
// Brief    : Signal bundle between a PWM source/consumer and pwm_capture.
//            The slave modport is the capture block; the master modport is
//            whatever drives the PWM input and reads the results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_capture_if #(
    parameter int CNT_W = 12
);
    logic             pwm_in;
    logic             en;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic [6:0]       duty_out;
    logic             valid;
    logic             overrun;
    logic             timeout;

    modport master (
        output pwm_in, en,
        input  period_out, high_out, duty_out, valid, overrun, timeout
    );

    modport slave (
        input  pwm_in, en,
        output period_out, high_out, duty_out, valid, overrun, timeout
    );
endinterface

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// Module   : pwm_capture
// Brief    : Measures period, high time and integer duty percentage of an
//            asynchronous PWM input, all in clk cycles. A background
//            restoring divider computes duty while the next period is timed.
//            Optional deglitch filter: define PWM_CAP_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture #(
    parameter int CNT_W    = 12,
    parameter int FILT_LEN = 3
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    pwm_capture_if.slave bus
);

    localparam int               NUM_W   = CNT_W + 7;
    localparam int               ITER_W  = $clog2(NUM_W);
    localparam logic [ITER_W-1:0] LAST_IT = ITER_W'(NUM_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    state_t state, next_state;

    logic sync1, sync2, s, s_d;
    logic rise, fall;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_cap;

    // FSM control strobes
    logic cnt_clr, cnt_one, cnt_inc, cap_high, launch, drop, set_timeout;

    // Divider state
    logic              div_busy;
    logic [ITER_W-1:0] div_iter;
    logic [NUM_W-1:0]  div_acc;
    logic [CNT_W-1:0]  div_rem;
    logic [CNT_W-1:0]  div_period;
    logic [CNT_W-1:0]  div_high;
    logic              div_idle;
    logic              div_finish;

    logic [NUM_W-1:0]  num;
    logic [CNT_W:0]    div_shift;
    logic [CNT_W-1:0]  div_diff;
    logic              div_ge;
    logic [CNT_W-1:0]  rem_next;
    logic [NUM_W-1:0]  acc_next;
    logic [6:0]        duty_sat;

    // Result registers
    logic [CNT_W-1:0] period_reg, high_reg;
    logic [6:0]       duty_reg;
    logic             valid_reg, overrun_reg, timeout_reg;

    // Reject a filter length that could never let the filtered signal change.
    generate
        if (FILT_LEN < 1) begin : g_bad_filt_len
            $error("pwm_capture: FILT_LEN must be at least 1");
        end
    endgenerate

    // Two-flop synchronizer plus the one-cycle delay used for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= bus.pwm_in;
            sync2 <= sync1;
            s_d   <= s;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [FCNT_W-1:0] filt_cnt;
    logic              filt_s;

    // Accept a new level only after it has held for FILT_LEN consecutive cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_s   <= 1'b0;
            filt_cnt <= '0;
        end else if (sync2 == filt_s) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FCNT_W'(FILT_LEN - 1)) begin
            filt_s   <= sync2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign s = filt_s;
`else
    assign s = sync2;
`endif

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // A finished divide still owns its result for the valid cycle.
    assign div_idle   = ~div_busy & ~valid_reg;
    assign div_finish = bus.en & div_busy & (div_iter == LAST_IT);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state and datapath strobes; en low forces IDLE from anywhere.
    always_comb begin
        next_state  = state;
        cnt_clr     = 1'b0;
        cnt_one     = 1'b0;
        cnt_inc     = 1'b0;
        cap_high    = 1'b0;
        launch      = 1'b0;
        drop        = 1'b0;
        set_timeout = 1'b0;
        if (!bus.en) begin
            next_state = ST_IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_ARM;
                    cnt_clr    = 1'b1;
                end
                ST_ARM: begin
                    if (rise) begin
                        next_state = ST_MEAS;
                        cnt_one    = 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        cnt_one = 1'b1;
                        if (div_idle) launch = 1'b1;
                        else          drop   = 1'b1;
                    end else begin
                        cap_high = fall;
                        if (cnt == CNT_MAX) begin
                            set_timeout = 1'b1;
                            cnt_clr     = 1'b1;
                            next_state  = ST_ARM;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Period counter and high-time capture; each rise opens a fresh period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            high_cap <= '0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_one) cnt <= CNT_W'(1);
            else if (cnt_inc) cnt <= cnt + 1'b1;

            if (cnt_clr || cnt_one) high_cap <= '0;
            else if (cap_high)      high_cap <= cnt;
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        num       = NUM_W'(high_cap) * NUM_W'(100);
        div_shift = {div_rem, div_acc[NUM_W-1]};
        div_ge    = (div_shift >= {1'b0, div_period});
        div_diff  = div_shift[CNT_W-1:0] - div_period;
        rem_next  = div_ge ? div_diff : div_shift[CNT_W-1:0];
        acc_next  = {div_acc[NUM_W-2:0], div_ge};
        duty_sat  = (acc_next > NUM_W'(100)) ? 7'd100 : acc_next[6:0];
    end

    // Divider sequencing and result update; en low discards an in-flight divide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_busy   <= 1'b0;
            div_iter   <= '0;
            div_acc    <= '0;
            div_rem    <= '0;
            div_period <= '0;
            div_high   <= '0;
            period_reg <= '0;
            high_reg   <= '0;
            duty_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (!bus.en) begin
                div_busy <= 1'b0;
            end else if (launch) begin
                div_busy   <= 1'b1;
                div_iter   <= '0;
                div_acc    <= num;
                div_rem    <= '0;
                div_period <= cnt;
                div_high   <= high_cap;
            end else if (div_busy) begin
                div_acc  <= acc_next;
                div_rem  <= rem_next;
                div_iter <= div_iter + 1'b1;
                if (div_iter == LAST_IT) begin
                    div_busy   <= 1'b0;
                    valid_reg  <= 1'b1;
                    period_reg <= div_period;
                    high_reg   <= div_high;
                    duty_reg   <= duty_sat;
                end
            end
        end
    end

    // Sticky status flags: overrun clears when idle, timeout clears on a fresh result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            if (!bus.en)   overrun_reg <= 1'b0;
            else if (drop) overrun_reg <= 1'b1;

            if (set_timeout)     timeout_reg <= 1'b1;
            else if (div_finish) timeout_reg <= 1'b0;
        end
    end

    assign bus.period_out = period_reg;
    assign bus.high_out   = high_reg;
    assign bus.duty_out   = duty_reg;
    assign bus.valid      = valid_reg;
    assign bus.overrun    = overrun_reg;
    assign bus.timeout    = timeout_reg;

endmodule

`default_nettype wire

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming PWM waveform, such as the output of the team's pwm_generator, and reports period, high time and duty cycle. All values are in clk cycles, and duty is an integer percentage. The block is the receive-side counterpart of the generator and is used for loopback self-test and for reading external PWM sources. Measurement runs continuously while enabled, with a background sequential divider computing duty.

Parameters:
CNT_W, 12, width of period/high counters; maximum measurable period is 2^CNT_W-1.
FILT_LEN, 3, stable-cycle count for the input deglitch filter (used only with PWM_CAP_FILTER_EN).

Ports:
clk  input  1  clock.
rst_n  input  1  reset, synchronous, active-low.
pwm_in  input  1  asynchronous PWM input.
en  input  1  1 = measure; 0 = idle and clear in-flight state.
period_out  output  CNT_W  last measured period in clk cycles.
high_out  output  CNT_W  last measured high time in clk cycles.
duty_out  output  7  floor(high_out*100/period_out), range 0..100.
valid  output  1  one-cycle pulse when the three result outputs update.
overrun  output  1  sticky: a completed period was dropped because the divider was busy.
timeout  output  1  sticky: no rising edge within 2^CNT_W-1 cycles.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0, state IDLE, counter 0, divider idle, synchronizer flops 0.
- Input path: 2-flop synchronizer, then optional filter, giving signal s.
  - rise = s & ~s_d; fall = ~s & s_d (s_d is s delayed 1 cycle).
  - Pin-to-edge-detect latency: 2 cycles (plus FILT_LEN with the filter enabled).
- FSM states:
  - IDLE: entered when en=0 from any state. Counter cleared, divider aborted, overrun cleared; result outputs and timeout hold. Exits to ARM when en=1.
  - ARM: waits for rise. On rise: cnt<=1, go to MEAS.
  - MEAS: cnt increments by 1 each cycle.
    - On fall: high_cap<=cnt.
    - On rise: period_cap<=cnt and cnt<=1 (new period starts). If the divider is idle, launch it with {high_cap,period_cap}; if busy, drop the result and set overrun.
    - If cnt==2^CNT_W-1 and no rise this cycle: set timeout, go to ARM.
- Count semantics: rising edges N cycles apart give period N. High for H cycles gives high_out H, which matches the generator's period_reg/t_on directly.
- Divider:
  - Unsigned restoring divider. Numerator = high_cap*100 (CNT_W+7 bits); denominator = period_cap.
  - Cycle 0 loads; CNT_W+7 iteration cycles follow, one quotient bit each (19 with the default width).
  - On the cycle after the last iteration: period_out, high_out and duty_out update together; valid=1 for one cycle; timeout cleared.
  - valid therefore fires exactly CNT_W+8 (20) cycles after the closing rise-detect cycle.
  - Quotient saturates to 100; the low 7 bits are used.
- Simultaneous rise and fall in one cycle is impossible on a single signal. A fall before the first rise (in ARM) is ignored.
- A period with no fall (high_cap stale) cannot occur after a rise. high_cap is cleared to 0 on each rise, so a missing fall yields duty 0.
- en falling mid-divide: divide discarded, no valid. rst_n mid-divide: full reset, no valid.
- The counter never wraps; saturation triggers the timeout path.

Optional Feature:
PWM_CAP_FILTER_EN
- Defined: s changes only after the synchronized input has held the new level for FILT_LEN consecutive cycles. Pulses shorter than FILT_LEN are ignored. Both edges are delayed equally, so measurements of pulses ≥FILT_LEN are unaffected.
- Undefined: s = synchronized input directly; every 1-cycle glitch produces edges.

Test Plan:
- Period 100, high 25, repeated 5 times -> valid once per period starting after the second rise; period_out=100, high_out=25, duty_out=25; overrun=0.
- Period 1000, high 990 -> duty_out=99; period 4095, high 1 -> period_out=4095, high_out=1, duty_out=0, timeout=0.
- Period 3, high 1 -> period_out=3, high_out=1, duty_out=33; overrun=1; valid at most once per 21 cycles.
- pwm_in held low 5000 cycles after one rise -> timeout=1 at cnt saturation, no valid. Then period 50, high 10 -> duty_out=20, timeout cleared on that valid.
- en deasserted 5 cycles after a rise launches the divider -> no valid, outputs hold previous values, overrun=0. Re-enable: first valid after two rises plus 20 cycles.
- With PWM_CAP_FILTER_EN: 1-cycle high glitch in the low phase of period 100 / high 40 -> period_out=100, duty_out=40. Without the macro: the glitch produces a short bogus period or overrun.
